// File: rtl/traffic_chk_pkg.sv
// traffic_pkg: shared definitions for the traffic checker and the matching
// traffic generator.
//   traffic_state_e       - checker FSM state encoding (IDLE / RUN / DRAIN)
//   CTRL_*                - bit positions inside control_reg
//   DEF_RX_LEN            - default stream data width in bits
//   DEF_CYCLES_PER_WINDOW - default rate-measurement window in clock cycles
package traffic_pkg;

    localparam int DEF_RX_LEN            = 128;
    localparam int DEF_CYCLES_PER_WINDOW = 250000000;

    localparam int CTRL_CLEAR  = 0;
    localparam int CTRL_ENABLE = 1;
    localparam int CTRL_CHECK  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } traffic_state_e;

endpackage

// File: rtl/traffic_chk_if.sv
// traffic_chk_if: receive stream carrying fixed-pattern test traffic.
//   rx_valid - beat present this cycle
//   rx_ben   - byte enables, bit k qualifies rx_data[8k+7:8k]
//   rx_data  - beat payload
//   rx_last  - final beat of a packet
// Handshake: valid-only. There is no ready; every cycle with rx_valid=1
// carries exactly one beat and the sink must consume it on that edge.
interface traffic_chk_if import traffic_pkg::*; #(
    parameter int RX_LEN = DEF_RX_LEN
) ();

    logic                rx_valid;
    logic [RX_LEN/8-1:0] rx_ben;
    logic [RX_LEN-1:0]   rx_data;
    logic                rx_last;

    modport master (output rx_valid, output rx_ben, output rx_data, output rx_last);
    modport slave  (input  rx_valid, input  rx_ben, input  rx_data, input  rx_last);

endinterface

// File: rtl/traffic_chk_ben_check.sv
// traffic_ben_check: combinational byte-enable analysis for one beat.
//   ben   in  - byte enables of the beat
//   last  in  - beat is the final beat of its packet
//   pop   out - number of enabled bytes
//   legal out - non-last beats must be all ones; last beats must be
//               nonzero and contiguous from bit 0
module traffic_ben_check #(
    parameter int BEN_W = 16,
    parameter int CNT_W = $clog2(BEN_W) + 1
) (
    input  logic [BEN_W-1:0] ben,
    input  logic             last,
    output logic [CNT_W-1:0] pop,
    output logic             legal
);

    logic [BEN_W-1:0] ben_inc;
    logic             contiguous;

    always_comb begin
        pop = '0;
        for (int k = 0; k < BEN_W; k++) begin
            pop = pop + CNT_W'(ben[k]);
        end
    end

    // A mask of the form 0..01..1 has no bit in common with itself plus one.
    assign ben_inc    = ben + BEN_W'(1);
    assign contiguous = ((ben_inc & ben) == '0);
    assign legal      = last ? ((ben != '0) && contiguous) : (&ben);

endmodule

// File: rtl/traffic_chk.sv
// traffic_chk: checks and measures an incoming test-traffic stream.
//   user_clk    in  - single clock, rising edge
//   user_reset  in  - synchronous active-high reset
//   control_reg in  - bit0 clear counters, bit1 enable, bit2 data-check enable
//   rx          in  - traffic_chk_if.slave stream (valid/ben/data/last)
//   error       out - sticky error flag
//   err_count   out - erroneous beats (saturating)
//   pkt_count   out - completed packets
//   byte_count  out - total enabled bytes consumed
//   rate_bytes  out - bytes consumed in the last completed window
//   rate_valid  out - one-cycle pulse when rate_bytes updates
//   state_dbg   out - current FSM state
module traffic_chk import traffic_pkg::*; #(
    parameter int RX_LEN            = DEF_RX_LEN,
    parameter int CYCLES_PER_WINDOW = DEF_CYCLES_PER_WINDOW
) (
    input  logic           user_clk,
    input  logic           user_reset,
    input  logic [31:0]    control_reg,
    traffic_chk_if.slave   rx,
    output logic           error,
    output logic [31:0]    err_count,
    output logic [31:0]    pkt_count,
    output logic [63:0]    byte_count,
    output logic [63:0]    rate_bytes,
    output logic           rate_valid,
    output traffic_state_e state_dbg
);

    localparam int BEN_W = RX_LEN / 8;
    localparam int LANES = RX_LEN / 32;
    localparam int CNT_W = $clog2(BEN_W) + 1;

    traffic_state_e state_q, state_d;
    logic           in_pkt_q;
    logic [31:0]    seq_q;
    logic [31:0]    win_cnt_q;
    logic [63:0]    win_acc_q;

    logic             clear, enable, check_en;
    logic             beat, in_run, win_end, pkt_open;
    logic [CNT_W-1:0] pop;
    logic             ben_legal, data_ok, beat_err;
    logic [31:0]      exp_lane;
    logic             ctrl_unused;

    assign clear       = control_reg[CTRL_CLEAR];
    assign enable      = control_reg[CTRL_ENABLE];
    assign check_en    = control_reg[CTRL_CHECK];
    assign ctrl_unused = ^control_reg[31:3];

    traffic_ben_check #(.BEN_W(BEN_W), .CNT_W(CNT_W)) u_ben_check (
        .ben   (rx.rx_ben),
        .last  (rx.rx_last),
        .pop   (pop),
        .legal (ben_legal)
    );

    // Only enabled bytes are compared; lane i carries seq*LANES+i.
    always_comb begin
        data_ok  = 1'b1;
        exp_lane = '0;
        for (int i = 0; i < LANES; i++) begin
            exp_lane = seq_q * 32'(LANES) + 32'(i);
            for (int b = 0; b < 4; b++) begin
                if (rx.rx_ben[4*i+b] && (rx.rx_data[32*i+8*b +: 8] != exp_lane[8*b +: 8])) begin
                    data_ok = 1'b0;
                end
            end
        end
    end

    assign beat_err = !ben_legal || (check_en && !data_ok);

    // A packet is still open after this edge if the current beat is a
    // non-last beat, or if no beat arrives and one was already open.
    assign pkt_open = beat ? !rx.rx_last : in_pkt_q;

    // FSM process 1: state register
    always_ff @(posedge user_clk) begin
        if (user_reset) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    // FSM process 2: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable) state_d = ST_RUN;
            ST_RUN:   if (!enable) state_d = pkt_open ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: if (beat && rx.rx_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM process 3: state-derived outputs
    always_comb begin
        beat      = rx.rx_valid && (state_q != ST_IDLE);
        in_run    = (state_q == ST_RUN);
        state_dbg = state_q;
    end

    assign win_end = in_run && (win_cnt_q == 32'(CYCLES_PER_WINDOW - 1));

    // Sequence and window tracking. Outside RUN the window is held at zero,
    // which both discards a partial window and starts a fresh one on entry.
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            seq_q     <= '0;
            in_pkt_q  <= 1'b0;
            win_cnt_q <= '0;
            win_acc_q <= '0;
        end else begin
            if (state_q == ST_IDLE) begin
                in_pkt_q <= 1'b0;
                if (enable) seq_q <= '0;
            end else if (beat) begin
                seq_q    <= seq_q + 32'd1;
                in_pkt_q <= !rx.rx_last;
            end

            if (!in_run || win_end) win_cnt_q <= '0;
            else                    win_cnt_q <= win_cnt_q + 32'd1;

            if (clear || !in_run || win_end) win_acc_q <= '0;
            else if (beat)                   win_acc_q <= win_acc_q + 64'(pop);
        end
    end

    // Counters and rate output; clear drops a coincident beat.
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            error      <= 1'b0;
            err_count  <= '0;
            pkt_count  <= '0;
            byte_count <= '0;
            rate_bytes <= '0;
            rate_valid <= 1'b0;
        end else begin
            rate_valid <= win_end && !clear;
            if (clear) begin
                error      <= 1'b0;
                err_count  <= '0;
                pkt_count  <= '0;
                byte_count <= '0;
                rate_bytes <= '0;
            end else begin
                if (win_end) rate_bytes <= win_acc_q + (beat ? 64'(pop) : 64'd0);
                if (beat) begin
                    byte_count <= byte_count + 64'(pop);
                    pkt_count  <= pkt_count + 32'(rx.rx_last);
                    if (beat_err) begin
                        error <= 1'b1;
                        if (err_count != 32'hFFFF_FFFF) err_count <= err_count + 32'd1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/traffic_chk.md
TRAFFIC_CHK -- requirements
Module: traffic_chk

Interface
REQ-001 The block SHALL have parameter RX_LEN, default 128, giving the stream data width in bits (multiple of 32).
REQ-002 The block SHALL have parameter CYCLES_PER_WINDOW, default 250000000, giving the rate-measurement window in user_clk cycles.
REQ-003 Port: user_clk  in  1  single clock, all logic on its rising edge.
REQ-004 Port: user_reset  in  1  synchronous, active-high reset.
REQ-005 Port: control_reg  in  32  bit0 = clear counters, bit1 = enable, bit2 = data-check enable, others ignored.
REQ-006 Port: rx_valid  in  1  beat present this cycle; there is no backpressure, so every valid beat is consumed.
REQ-007 Port: rx_ben  in  RX_LEN/8  byte enables, bit k qualifies rx_data[8k+7:8k].
REQ-008 Port: rx_data  in  RX_LEN  beat payload.
REQ-009 Port: rx_last  in  1  final beat of a packet.
REQ-010 Port: error  out  1  sticky error flag.
REQ-011 Port: err_count  out  32  number of erroneous beats.
REQ-012 Port: pkt_count  out  32  number of packets completed (rx_last beats).
REQ-013 Port: byte_count  out  64  total enabled bytes consumed.
REQ-014 Port: rate_bytes  out  64  bytes consumed in the last completed window.
REQ-015 Port: rate_valid  out  1  one-cycle pulse when rate_bytes updates.

Function
REQ-016 FSM states SHALL be IDLE, RUN and DRAIN.
- IDLE->RUN: when enable=1.
- RUN->DRAIN: enable=0 while mid-packet.
- RUN->IDLE: enable=0 with no open packet.
- DRAIN->IDLE: on the rx_last beat.
REQ-017 Beats SHALL be processed only in RUN and DRAIN; beats in IDLE are ignored entirely.
REQ-018 On each IDLE->RUN transition, the beat sequence number seq, the window cycle counter and the window byte accumulator SHALL reset to 0.
REQ-019 Each processed beat SHALL add popcount(rx_ben) to byte_count and to the window accumulator, add rx_last to pkt_count, and increment seq.
- Counter and error outputs SHALL reflect a beat exactly one cycle after it.
REQ-020 rx_ben legality:
- Non-last beat: rx_ben SHALL be all ones.
- Last beat: rx_ben SHALL be nonzero and contiguous from bit 0.
- Any other value is a ben error.
REQ-021 With check enable set, 32-bit lane i of the beat is expected to equal (seq*(RX_LEN/32)+i) mod 2^32.
- Any enabled byte differing from expected is a data error.
- seq SHALL advance even on a mismatch; there is no resync.
REQ-022 A beat with a ben or data error SHALL increment err_count by one, saturating at 0xFFFFFFFF, and SHALL set error.
- error stays set until clear or reset.
REQ-023 byte_count and pkt_count SHALL wrap modulo 2^64 and 2^32 respectively.
REQ-024 In RUN the window counter SHALL increment every cycle.
- On the cycle it equals CYCLES_PER_WINDOW-1, rate_bytes is loaded with the accumulator plus that cycle's beat bytes, rate_valid pulses the next cycle, and the counter and accumulator restart at 0.
REQ-025 Leaving RUN SHALL discard the partial window without a rate_valid pulse; rate_bytes SHALL hold its last value.
REQ-026 Clear (bit0=1) SHALL zero error, err_count, pkt_count, byte_count, rate_bytes and the window accumulator on the next edge.
- Clear SHALL take priority over a simultaneous beat, which is dropped from all counts.
- Clear SHALL NOT change the FSM state or seq.

Reset
REQ-027 user_reset=1 SHALL force the state to IDLE and zero seq, the window counter, the accumulator and every output, with rate_valid=0.
REQ-028 Reset asserted mid-packet or mid-window SHALL abandon it; no rate_valid pulse and no partial counts survive.

Structure
REQ-029 Package traffic_pkg SHALL hold the state enum, the control_reg bit index constants and the default RX_LEN and CYCLES_PER_WINDOW values.
- The traffic generator shares this package.
REQ-030 Sub-module traffic_ben_check SHALL compute popcount and the legality flag combinationally from rx_ben and rx_last.

Verification (CYCLES_PER_WINDOW=100, RX_LEN=128)
REQ-031 Enable a 4-beat packet, seq 0..3, correct lanes, full ben on every beat -> pkt_count=1, byte_count=64, err_count=0, error=0.
REQ-032 Corrupt lane 2 of beat 1 with check enable set -> err_count=1 and error=1 one cycle after the beat; a later clean packet leaves err_count at 1.
REQ-033 Last beat with rx_ben=16'h00F0 -> ben error counted; with rx_ben=16'h000F -> legal, byte_count adds 4.
REQ-034 Continuous beats with full ben for 100 cycles of RUN -> rate_bytes=1600 with one rate_valid pulse, repeating every 100 cycles.
REQ-035 Drop enable after beat 2 of a 4-beat packet -> state is DRAIN, beats 3-4 are counted, then IDLE; following beats are ignored; no rate_valid.
REQ-036 Clear coincident with a valid beat, then reset mid-packet -> all counters 0, the beat is not counted, state IDLE.
